tilelink_ad_initiator: RTL and testbench
========================================

# tilelink_ad_initiator

- Single-outstanding TileLink TL-UL initiator: drives channel A and consumes channel D.
- Accepts commands (Get or PutFullData) on a simple valid/ready command port, plus a write-data beat stream.
- Issues the matching A beats, checks every D beat, and returns response beats on a response stream.
- Sits in the formal wrapper on the Rocket tile's slave port (currently tied off), driven by nondeterministic command sources.

## Interface
Parameters:
- `XLEN`, 32: data width in bits, 32 or 64; `XB = XLEN/8`.
- `MAX_SIZE`, 6: largest legal log2 transfer size in bytes.
- `TIMEOUT`, 256: cycles allowed in D wait without a D handshake.

Ports:
- `clock` in 1: the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_write` in 1: 1 = PutFullData, 0 = Get.
- `cmd_size` in 3, `cmd_source` in 5, `cmd_address` in 32: command fields.
- `wr_valid` in 1, `wr_ready` out 1: write-data handshake, one handshake per Put A beat.
- `wr_data` in XLEN, `wr_mask` in XB: write-data beat.
- `a_valid` out 1, `a_ready` in 1: channel A handshake.
- `a_opcode` out 3, `a_param` out 3, `a_size` out 3, `a_source` out 5: channel A fields.
- `a_address` out 32, `a_mask` out XB, `a_data` out XLEN: channel A fields.
- `d_valid` in 1, `d_ready` out 1: channel D handshake.
- `d_opcode` in 3, `d_size` in 3, `d_source` in 5, `d_data` in XLEN: channel D fields.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_data` out XLEN, `rsp_last` out 1, `rsp_error` out 1: response beat.
- `stray_d` out 1: one-cycle pulse when a D beat arrives while no transaction is outstanding.

## Operation
- States: IDLE, CHK, SEND_A, WAIT_D.
- `beats = max(1, (1<<size)/XB)`.
- IDLE:
  - `cmd_ready = 1`.
  - On a command handshake: latch all command fields, clear the error flag and beat counter, go to CHK.
- CHK (one cycle):
  - If `cmd_size > MAX_SIZE` or the address is not aligned to `1<<size`: load one response beat (`rsp_data = 0`, `rsp_last = 1`, `rsp_error = 1`), then go to IDLE once it is accepted. No A traffic is issued.
  - Otherwise go to SEND_A.
- SEND_A, Get:
  - `a_valid = 1`, `a_opcode = 4`, `a_mask` = all ones restricted to the size/address lanes, `a_data = 0`.
  - One beat; on handshake go to WAIT_D.
- SEND_A, Put:
  - `a_valid = wr_valid`, `a_opcode = 0`.
  - `a_data` and `a_mask` pass through combinationally from `wr_data` and `wr_mask`.
  - `wr_ready = a_ready`.
  - Count A handshakes; after `beats` of them go to WAIT_D.
- SEND_A, all commands: `a_param = 0`; `a_size`, `a_source` and `a_address` hold the latched values for every beat.
- WAIT_D:
  - `d_ready = !rsp_valid || rsp_ready`.
  - Each D handshake loads one response beat with `rsp_data = d_data` (0 for Put).
  - Expected D beats: Get = `beats` with opcode 1; Put = 1 with opcode 0.
  - A mismatch in `d_opcode`, `d_size` or `d_source` sets `rsp_error` on that beat and all later beats of the transaction.
  - The final expected beat carries `rsp_last = 1`; go to IDLE.
- Timeout:
  - A counter runs in WAIT_D and clears on every D handshake.
  - When it reaches `TIMEOUT-1`, emit one response beat (`rsp_data = 0`, `rsp_last = 1`, `rsp_error = 1`) and go to IDLE.
- Stray D beats:
  - In IDLE, CHK and SEND_A: `d_ready = 1`.
  - Any D handshake in these states pulses `stray_d` and is otherwise dropped.

## Timing
- Reset values: state IDLE; `a_valid`, `d_ready`, `wr_ready`, `rsp_valid` and `stray_d` are 0.
- `cmd_ready = 0` while `reset_n` is low, and 1 from the first cycle after deassertion.
- All response outputs are registered and held stable while `rsp_valid && !rsp_ready`.
- A fields are stable while `a_valid && !a_ready`, except the pass-through Put `a_data`/`a_mask`, which the write source must hold.
- Latency, Get with 0-delay slave: command handshake cycle N, `a_valid` at N+2, first `rsp_valid` one cycle after the first D handshake.
- Simultaneous D handshake and timeout expiry: the D beat wins and the counter clears.
- Reset mid-transaction: return to IDLE immediately. No response is produced for the aborted command.

## Structure
- Package `tilelink_pkg`:
  - A opcodes (Get=4, PutFull=0, PutPartial=1, Arith=2, Logical=3, Intent=5).
  - D opcodes (AccessAck=0, AccessAckData=1, HintAck=2).
  - State enum.
  - `beats_for(size, XB)` function.
- Single module; no sub-module is warranted.

## Test plan
- Get: `size = 2` at 0x100, XLEN 32, slave returns data 0xDEADBEEF with opcode 1 -> one beat with `rsp_data = 0xDEADBEEF`, `rsp_last = 1`, `rsp_error = 0`.
- Put: `size = 4` (16 B, 4 beats), `wr_valid` gapped every other cycle -> exactly 4 A beats, opcode 0, address constant, then one ack -> `rsp_last = 1`, `rsp_error = 0`.
- Misaligned Get: `size = 3` at 0x104 -> no `a_valid` ever, one response with `rsp_error = 1` two cycles after the command.
- Put ack with wrong `d_source` (5 instead of 3) -> `rsp_error = 1`.
- Get where the slave never answers, `TIMEOUT = 8` -> `rsp_error = 1` after 8 WAIT_D cycles. A D beat arriving afterwards -> `stray_d` pulses once.
- Multi-beat Get with `rsp_ready` held low 5 cycles -> `d_ready` drops, `rsp_data` holds, and no beat is lost. `reset_n` pulsed low mid-burst -> all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/tilelink_ad_initiator_pkg.sv
// Shared TileLink TL-UL encodings, FSM states and beat-count helper for the
// channel A/D initiator.
package tilelink_pkg;

    typedef enum logic [2:0] {
        A_PUT_FULL    = 3'd0,
        A_PUT_PARTIAL = 3'd1,
        A_ARITH       = 3'd2,
        A_LOGICAL     = 3'd3,
        A_GET         = 3'd4,
        A_INTENT      = 3'd5
    } a_opcode_e;

    typedef enum logic [2:0] {
        D_ACCESS_ACK      = 3'd0,
        D_ACCESS_ACK_DATA = 3'd1,
        D_HINT_ACK        = 3'd2
    } d_opcode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHK,
        S_SEND_A,
        S_WAIT_D
    } state_e;

    // Transfers narrower than the bus still occupy one full beat.
    function automatic int unsigned beats_for(input logic [2:0] size, input int unsigned xb);
        int unsigned bytes;
        bytes = 32'd1 << size;
        return (bytes <= xb) ? 32'd1 : bytes / xb;
    endfunction

endpackage

// File: rtl/tilelink_ad_initiator.sv
// Single-outstanding TL-UL initiator: turns Get/PutFullData commands into
// channel A beats, checks channel D replies and streams back response beats.
module tilelink_ad_initiator
    import tilelink_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MAX_SIZE = 6,
    parameter int TIMEOUT  = 256,
    localparam int XB      = XLEN / 8
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_write,
    input  logic [2:0]      cmd_size,
    input  logic [4:0]      cmd_source,
    input  logic [31:0]     cmd_address,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [XLEN-1:0] wr_data,
    input  logic [XB-1:0]   wr_mask,
    output logic            a_valid,
    input  logic            a_ready,
    output logic [2:0]      a_opcode,
    output logic [2:0]      a_param,
    output logic [2:0]      a_size,
    output logic [4:0]      a_source,
    output logic [31:0]     a_address,
    output logic [XB-1:0]   a_mask,
    output logic [XLEN-1:0] a_data,
    input  logic            d_valid,
    output logic            d_ready,
    input  logic [2:0]      d_opcode,
    input  logic [2:0]      d_size,
    input  logic [4:0]      d_source,
    input  logic [XLEN-1:0] d_data,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_last,
    output logic            rsp_error,
    output logic            stray_d
);

    localparam int LB = (XB > 1) ? $clog2(XB) : 1;
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [3:0]    MAX_SIZE_L = 4'(MAX_SIZE);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);

    function automatic logic [XB-1:0] lane_mask(input logic [2:0] size, input logic [31:0] addr);
        int unsigned bytes;
        logic [XB-1:0] low;
        bytes = 32'd1 << size;
        if (bytes >= 32'(XB)) return '1;
        low = XB'((32'd1 << bytes) - 32'd1);
        return low << addr[LB-1:0];
    endfunction

    state_e        state;
    logic          write_q;
    logic [2:0]    size_q;
    logic [4:0]    source_q;
    logic [31:0]   addr_q;
    logic          err_q;
    logic          chk_loaded;
    logic [7:0]    beat_cnt;
    logic [7:0]    beats;
    logic [TW-1:0] to_cnt;
    logic [31:0]   size_mask;
    logic          cmd_hs, a_hs, d_hs, rsp_free, bad_cmd, d_err, exp_last, timeout_hit;
    logic          rsp_load, rsp_last_n, rsp_error_n;
    logic [XLEN-1:0] rsp_data_n;

    assign beats     = 8'(beats_for(size_q, XB));
    assign size_mask = (32'd1 << size_q) - 32'd1;
    assign bad_cmd   = ({1'b0, size_q} > MAX_SIZE_L) || ((addr_q & size_mask) != 32'd0);

    assign cmd_ready = reset_n && (state == S_IDLE);
    assign a_valid   = (state == S_SEND_A) && (write_q ? wr_valid : 1'b1);
    assign wr_ready  = (state == S_SEND_A) && write_q && a_ready;
    assign rsp_free  = !rsp_valid || rsp_ready;
    assign d_ready   = reset_n && ((state == S_WAIT_D) ? rsp_free : 1'b1);

    assign a_opcode  = write_q ? A_PUT_FULL : A_GET;
    assign a_param   = 3'd0;
    assign a_size    = size_q;
    assign a_source  = source_q;
    assign a_address = addr_q;
    assign a_mask    = write_q ? wr_mask : lane_mask(size_q, addr_q);
    assign a_data    = write_q ? wr_data : '0;

    assign cmd_hs = cmd_valid && cmd_ready;
    assign a_hs   = a_valid && a_ready;
    assign d_hs   = d_valid && d_ready;

    assign d_err = (d_opcode != (write_q ? D_ACCESS_ACK : D_ACCESS_ACK_DATA)) ||
                   (d_size != size_q) || (d_source != source_q);
    assign exp_last    = write_q || (beat_cnt == beats - 8'd1);
    assign timeout_hit = (state == S_WAIT_D) && !d_hs && (to_cnt == TO_LAST) && rsp_free;

    // Error responses (rejected command, timeout) default to data 0, last, error.
    always_comb begin
        rsp_load    = 1'b0;
        rsp_data_n  = '0;
        rsp_last_n  = 1'b1;
        rsp_error_n = 1'b1;
        case (state)
            S_CHK: begin
                if (bad_cmd && !chk_loaded && rsp_free) rsp_load = 1'b1;
            end
            S_WAIT_D: begin
                if (d_hs) begin
                    rsp_load    = 1'b1;
                    rsp_data_n  = write_q ? '0 : d_data;
                    rsp_last_n  = exp_last;
                    rsp_error_n = err_q || d_err;
                end else if (timeout_hit) begin
                    rsp_load = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (cmd_hs) begin
            write_q  <= cmd_write;
            size_q   <= cmd_size;
            source_q <= cmd_source;
            addr_q   <= cmd_address;
        end
        if (rsp_load) begin
            rsp_data  <= rsp_data_n;
            rsp_last  <= rsp_last_n;
            rsp_error <= rsp_error_n;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            rsp_valid  <= 1'b0;
            stray_d    <= 1'b0;
            err_q      <= 1'b0;
            chk_loaded <= 1'b0;
            beat_cnt   <= '0;
            to_cnt     <= '0;
        end else begin
            stray_d <= d_hs && (state != S_WAIT_D);
            if (rsp_load)       rsp_valid <= 1'b1;
            else if (rsp_ready) rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_hs) begin
                        state      <= S_CHK;
                        err_q      <= 1'b0;
                        chk_loaded <= 1'b0;
                        beat_cnt   <= '0;
                        to_cnt     <= '0;
                    end
                end
                S_CHK: begin
                    if (!bad_cmd)                    state      <= S_SEND_A;
                    else if (!chk_loaded)            chk_loaded <= rsp_load;
                    else if (rsp_valid && rsp_ready) state      <= S_IDLE;
                end
                S_SEND_A: begin
                    if (a_hs) begin
                        if (!write_q || beat_cnt == beats - 8'd1) begin
                            state    <= S_WAIT_D;
                            beat_cnt <= '0;
                            to_cnt   <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                end
                S_WAIT_D: begin
                    // A D beat in the expiry cycle wins over the timeout.
                    if (d_hs) begin
                        to_cnt <= '0;
                        err_q  <= err_q || d_err;
                        if (exp_last) state    <= S_IDLE;
                        else          beat_cnt <= beat_cnt + 8'd1;
                    end else if (timeout_hit) begin
                        state <= S_IDLE;
                    end else if (to_cnt != TO_LAST) begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tilelink_ad_initiator.sv
// Directed bench for tilelink_ad_initiator with a response scoreboard and
// channel A / stray-D monitors.
module tb_tilelink_ad_initiator;

    localparam int XLEN = 32;
    localparam int XB   = XLEN / 8;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic            last;
        logic            error;
    } rsp_t;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            cmd_valid, cmd_ready, cmd_write;
    logic [2:0]      cmd_size;
    logic [4:0]      cmd_source;
    logic [31:0]     cmd_address;
    logic            wr_valid, wr_ready;
    logic [XLEN-1:0] wr_data;
    logic [XB-1:0]   wr_mask;
    logic            a_valid, a_ready;
    logic [2:0]      a_opcode, a_param, a_size;
    logic [4:0]      a_source;
    logic [31:0]     a_address;
    logic [XB-1:0]   a_mask;
    logic [XLEN-1:0] a_data;
    logic            d_valid, d_ready;
    logic [2:0]      d_opcode, d_size;
    logic [4:0]      d_source;
    logic [XLEN-1:0] d_data;
    logic            rsp_valid, rsp_ready;
    logic [XLEN-1:0] rsp_data;
    logic            rsp_last, rsp_error, stray_d;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   a_beats  = 0;
    int   stray_cnt = 0;
    logic [2:0]  exp_a_opcode = 3'd4;
    logic [31:0] exp_a_addr   = 32'd0;
    rsp_t exp_q[$];

    tilelink_ad_initiator #(.XLEN(XLEN), .MAX_SIZE(6), .TIMEOUT(8)) dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_size(cmd_size), .cmd_source(cmd_source), .cmd_address(cmd_address),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_mask(wr_mask),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
        .a_data(a_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
        .d_source(d_source), .d_data(d_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .rsp_error(rsp_error), .stray_d(stray_d)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Response scoreboard: every accepted beat must match the oldest expectation.
    always @(negedge clock) begin
        if (reset_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check("rsp_data",  64'(rsp_data),  64'(e.data));
                check("rsp_last",  64'(rsp_last),  64'(e.last));
                check("rsp_error", 64'(rsp_error), 64'(e.error));
            end
        end
    end

    always @(negedge clock) begin
        if (reset_n && a_valid && a_ready) begin
            a_beats++;
            check("a_opcode",  64'(a_opcode),  64'(exp_a_opcode));
            check("a_address", 64'(a_address), 64'(exp_a_addr));
            check("a_data",    64'(a_data),    (exp_a_opcode == 3'd0) ? 64'(wr_data) : 64'd0);
        end
        if (reset_n && stray_d) stray_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_cmd(input logic w, input logic [2:0] sz, input logic [4:0] src,
                            input logic [31:0] adr);
        int k = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_size = sz; cmd_source = src; cmd_address = adr;
        @(negedge clock);
        while (!cmd_ready && k < 20) begin @(negedge clock); k++; end
        check("cmd_handshake", 64'(cmd_ready), 64'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_a_hs();
        int k = 0;
        @(negedge clock);
        while (!(a_valid && a_ready) && k < 20) begin @(negedge clock); k++; end
        check("a_handshake", 64'(a_valid), 64'd1);
        step();
    endtask

    task automatic put_beat(input logic [XLEN-1:0] dat);
        int k = 0;
        wr_valid = 1'b1; wr_data = dat; wr_mask = '1;
        @(negedge clock);
        while (!wr_ready && k < 20) begin @(negedge clock); k++; end
        check("wr_handshake", 64'(wr_ready), 64'd1);
        step();
        wr_valid = 1'b0;
    endtask

    task automatic drive_d(input logic [2:0] op, input logic [2:0] sz, input logic [4:0] src,
                           input logic [XLEN-1:0] dat);
        int k = 0;
        d_valid = 1'b1; d_opcode = op; d_size = sz; d_source = src; d_data = dat;
        @(negedge clock);
        while (!d_ready && k < 40) begin @(negedge clock); k++; end
        check("d_handshake", 64'(d_ready), 64'd1);
        step();
        d_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 50) begin step(); k++; end
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int c;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = '0; cmd_source = '0;
        cmd_address = '0; wr_valid = 1'b0; wr_data = '0; wr_mask = '0; a_ready = 1'b1;
        d_valid = 1'b0; d_opcode = '0; d_size = '0; d_source = '0; d_data = '0; rsp_ready = 1'b1;

        // Reset values
        repeat (2) @(posedge clock);
        #1;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_a_valid",   64'(a_valid),   64'd0);
        check("rst_d_ready",   64'(d_ready),   64'd0);
        check("rst_wr_ready",  64'(wr_ready),  64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_stray_d",   64'(stray_d),   64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        step();
        check("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);

        // Get size 2 at 0x100: latency and data return
        exp_a_opcode = 3'd4; exp_a_addr = 32'h100; a_beats = 0;
        send_cmd(1'b0, 3'd2, 5'd3, 32'h100);
        check("get_a_valid_n1", 64'(a_valid), 64'd0);
        step();
        check("get_a_valid_n2", 64'(a_valid), 64'd1);
        check("get_a_mask",     64'(a_mask),  64'hF);
        check("get_a_size",     64'(a_size),  64'd2);
        check("get_a_param",    64'(a_param), 64'd0);
        step();
        exp_q.push_back('{data: 32'hDEADBEEF, last: 1'b1, error: 1'b0});
        drive_d(3'd1, 3'd2, 5'd3, 32'hDEADBEEF);
        check("get_rsp_latency", 64'(rsp_valid), 64'd1);
        drain();
        check("get_a_beats", 64'(a_beats), 64'd1);

        // Halfword Get at 0x102: upper two lanes only
        exp_a_addr = 32'h102; a_beats = 0;
        send_cmd(1'b0, 3'd1, 5'd4, 32'h102);
        step();
        check("half_a_mask", 64'(a_mask), 64'hC);
        step();
        exp_q.push_back('{data: 32'h12340000, last: 1'b1, error: 1'b0});
        drive_d(3'd1, 3'd1, 5'd4, 32'h12340000);
        drain();

        // Put 16 bytes, write data gapped every other cycle
        exp_a_opcode = 3'd0; exp_a_addr = 32'h200; a_beats = 0;
        send_cmd(1'b1, 3'd4, 5'd3, 32'h200);
        for (int i = 0; i < 4; i++) begin
            put_beat(32'hC0DE0000 + 32'(i));
            step();
        end
        check("put_a_beats", 64'(a_beats), 64'd4);
        check("put_no_extra_a", 64'(a_valid), 64'd0);
        exp_q.push_back('{data: '0, last: 1'b1, error: 1'b0});
        drive_d(3'd0, 3'd4, 5'd3, 32'h0);
        drain();

        // Misaligned Get: error two cycles after the command, no A traffic
        exp_a_opcode = 3'd4; exp_a_addr = 32'h104; a_beats = 0;
        exp_q.push_back('{data: '0, last: 1'b1, error: 1'b1});
        send_cmd(1'b0, 3'd3, 5'd1, 32'h104);
        check("misalign_rsp_n1", 64'(rsp_valid), 64'd0);
        step();
        check("misalign_rsp_n2", 64'(rsp_valid), 64'd1);
        drain();
        repeat (3) step();
        check("misalign_no_a", 64'(a_beats), 64'd0);

        // Put ack with wrong source
        exp_a_opcode = 3'd0; exp_a_addr = 32'h300;
        send_cmd(1'b1, 3'd2, 5'd3, 32'h300);
        put_beat(32'h55AA55AA);
        exp_q.push_back('{data: '0, last: 1'b1, error: 1'b1});
        drive_d(3'd0, 3'd2, 5'd5, 32'h0);
        drain();

        // Unanswered Get times out, late D beat is stray
        exp_a_opcode = 3'd4; exp_a_addr = 32'h400;
        send_cmd(1'b0, 3'd2, 5'd7, 32'h400);
        wait_a_hs();
        exp_q.push_back('{data: '0, last: 1'b1, error: 1'b1});
        c = 0;
        while (!rsp_valid && c < 50) begin step(); c++; end
        check("timeout_cycles", 64'(c), 64'd8);
        drain();
        stray_cnt = 0;
        drive_d(3'd1, 3'd2, 5'd7, 32'h1);
        repeat (3) step();
        check("stray_pulse_count", 64'(stray_cnt), 64'd1);

        // Multi-beat Get with response backpressure
        exp_a_addr = 32'h500;
        rsp_ready = 1'b0;
        send_cmd(1'b0, 3'd4, 5'd2, 32'h500);
        wait_a_hs();
        exp_q.push_back('{data: 32'hA0, last: 1'b0, error: 1'b0});
        drive_d(3'd1, 3'd4, 5'd2, 32'hA0);
        for (int i = 0; i < 5; i++) begin
            check("stall_d_ready",  64'(d_ready),  64'd0);
            check("stall_rsp_data", 64'(rsp_data), 64'hA0);
            step();
        end
        rsp_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            exp_q.push_back('{data: 32'hA0 + 32'(i), last: (i == 3), error: 1'b0});
            drive_d(3'd1, 3'd4, 5'd2, 32'hA0 + 32'(i));
        end
        drain();

        // Reset mid-burst: outputs drop asynchronously, aborted response discarded
        rsp_ready = 1'b0;
        exp_a_addr = 32'h600;
        send_cmd(1'b0, 3'd4, 5'd2, 32'h600);
        wait_a_hs();
        drive_d(3'd1, 3'd4, 5'd2, 32'hB0);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("arst_d_ready",   64'(d_ready),   64'd0);
        check("arst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("arst_a_valid",   64'(a_valid),   64'd0);
        check("arst_wr_ready",  64'(wr_ready),  64'd0);
        check("arst_stray_d",   64'(stray_d),   64'd0);
        exp_q.delete();
        @(negedge clock);
        reset_n = 1'b1;
        rsp_ready = 1'b1;
        step();
        check("recover_cmd_ready", 64'(cmd_ready), 64'd1);
        exp_a_addr = 32'h700;
        send_cmd(1'b0, 3'd2, 5'd9, 32'h700);
        wait_a_hs();
        exp_q.push_back('{data: 32'h0BADF00D, last: 1'b1, error: 1'b0});
        drive_d(3'd1, 3'd2, 5'd9, 32'h0BADF00D);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
